// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction control sequencer: states, strobe and
// bus bit positions, opcodes and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_FAULT
  } ctrl_state_t;

  // enable[] load-strobe positions (R0-R15 occupy [15:0])
  localparam int EN_ZIN   = 18;
  localparam int EN_YIN   = 19;
  localparam int EN_PCIN  = 20;
  localparam int EN_MDRIN = 21;
  localparam int EN_IRIN  = 23;
  localparam int EN_MARIN = 25;
  localparam int EN_INCPC = 27;

  // busSelect[] source positions (R0-R15 occupy [15:0])
  localparam int BS_ZHIGH = 18;
  localparam int BS_ZLOW  = 19;
  localparam int BS_PC    = 20;
  localparam int BS_MDR   = 21;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;

endpackage

// File: rtl/alu_op_decode.sv
// Maps an instruction opcode to its ALU operation code and a legality flag.
module alu_op_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output logic           legal,
  output logic [3:0]     alu_code
);

  always_comb begin
    legal    = 1'b1;
    alu_code = ALU_NONE;
    case (opcode)
      OPW'(OP_ADD): alu_code = ALU_ADD;
      OPW'(OP_SUB): alu_code = ALU_SUB;
      OPW'(OP_AND): alu_code = ALU_AND;
      OPW'(OP_OR):  alu_code = ALU_OR;
      default:      legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer for register-register ALU instructions; Moore outputs
// decoded from the state register and the current instruction register.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | stopped, waiting for run
// ST_T0    | PC -> MAR, PC+1 -> Z
// ST_T1    | Z -> PC, memory data -> MDR; holds until mem_ready
// ST_T2    | MDR -> IR
// ST_T3    | Rb -> Y, or trap to FAULT on an unsupported opcode
// ST_T4    | Rc through ALU -> Z
// ST_T5    | Zlow -> Ra, instruction complete
// ST_FAULT | illegal opcode seen; exits only through clr
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic        MD_Read,
  output logic [3:0]  Control_Signals,
  output logic        instr_done,
  output logic        illegal
);

  ctrl_state_t state;
  logic        op_legal;
  logic [3:0]  op_alu;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        unused_ir_bits;

  assign ra             = ir[26:23];
  assign rb             = ir[22:19];
  assign rc             = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  alu_op_decode #(.OPW(OPW)) u_alu_op_decode (
    .opcode   (ir[31 -: OPW]),
    .legal    (op_legal),
    .alu_code (op_alu)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (run) state <= ST_T0;
        ST_T0:    state <= ST_T1;
        ST_T1:    if (mem_ready) state <= ST_T2;
        ST_T2:    state <= ST_T3;
        ST_T3:    state <= op_legal ? ST_T4 : ST_FAULT;
        ST_T4:    state <= ST_T5;
        ST_T5:    state <= run ? ST_T0 : ST_IDLE;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // IDLE is the reset state, so its all-zero decode also covers clr=0.
  always_comb begin
    enable          = '0;
    busSelect       = '0;
    MD_Read         = 1'b0;
    Control_Signals = ALU_NONE;
    instr_done      = 1'b0;
    illegal         = 1'b0;
    case (state)
      ST_T0: begin
        busSelect[BS_PC]  = 1'b1;
        enable[EN_MARIN]  = 1'b1;
        enable[EN_INCPC]  = 1'b1;
        enable[EN_ZIN]    = 1'b1;
      end
      ST_T1: begin
        busSelect[BS_ZLOW] = 1'b1;
        enable[EN_PCIN]    = 1'b1;
        enable[EN_MDRIN]   = 1'b1;
        MD_Read            = 1'b1;
      end
      ST_T2: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IRIN]   = 1'b1;
      end
      ST_T3: begin
        if (op_legal) begin
          busSelect[{1'b0, rb}] = 1'b1;
          enable[EN_YIN]        = 1'b1;
        end
      end
      ST_T4: begin
        busSelect[{1'b0, rc}] = 1'b1;
        enable[EN_ZIN]        = 1'b1;
        Control_Signals       = op_alu;
      end
      ST_T5: begin
        busSelect[BS_ZLOW] = 1'b1;
        enable[{1'b0, ra}] = 1'b1;
        instr_done         = 1'b1;
      end
      ST_FAULT: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: per-cycle output vectors,
// memory wait, illegal trap, back-to-back issue and asynchronous reset.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic        MD_Read;
  logic [3:0]  Control_Signals;
  logic        instr_done;
  logic        illegal;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic prev_ill = 1'b0;

  always #5 clk = ~clk;

  control_sequencer #(.OPW(5)) dut (
    .clk             (clk),
    .clr             (clr),
    .run             (run),
    .ir              (ir),
    .mem_ready       (mem_ready),
    .enable          (enable),
    .busSelect       (busSelect),
    .MD_Read         (MD_Read),
    .Control_Signals (Control_Signals),
    .instr_done      (instr_done),
    .illegal         (illegal)
  );

  function automatic logic [31:0] b(input int i);
    return 32'h1 << i;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] en, input logic [31:0] bs,
                            input logic mdr, input logic [3:0] cs, input logic done,
                            input logic ill);
    logic [70:0] obs;
    logic [70:0] exp;
    obs = {enable, busSelect, MD_Read, Control_Signals, instr_done, illegal};
    exp = {en, bs, mdr, cs, done, ill};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp_zero(input string tag);
    expect_out(tag, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask
  task automatic exp_t0(input string tag);
    expect_out(tag, b(25) | b(27) | b(18), b(20), 1'b0, 4'd0, 1'b0, 1'b0);
  endtask
  task automatic exp_t1(input string tag);
    expect_out(tag, b(20) | b(21), b(19), 1'b1, 4'd0, 1'b0, 1'b0);
  endtask
  task automatic exp_t2(input string tag);
    expect_out(tag, b(23), b(21), 1'b0, 4'd0, 1'b0, 1'b0);
  endtask
  task automatic exp_t3(input string tag, input int rb);
    expect_out(tag, b(19), b(rb), 1'b0, 4'd0, 1'b0, 1'b0);
  endtask
  task automatic exp_t4(input string tag, input int rc, input logic [3:0] code);
    expect_out(tag, b(18), b(rc), 1'b0, code, 1'b0, 1'b0);
  endtask
  task automatic exp_t5(input string tag, input int ra);
    expect_out(tag, b(ra), b(19), 1'b0, 4'd0, 1'b1, 1'b0);
  endtask
  task automatic exp_fault(input string tag);
    expect_out(tag, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  // Continuous invariants: bus source is never multiply driven, illegal only drops under clr.
  always @(negedge clk) begin
    checks++;
    assert ($countones(busSelect) <= 1) else begin
      failures++;
      $error("FAIL bus_onehot observed=%h expected=at_most_one_bit", busSelect);
    end
    if (clr === 1'b1 && prev_ill) begin
      checks++;
      assert (illegal === 1'b1) else begin
        failures++;
        $error("FAIL illegal_sticky observed=%b expected=1", illegal);
      end
    end
    prev_ill = (clr === 1'b1) ? illegal : 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int d1;
    int d2;
    clr       = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b1;
    ir        = 32'h0;
    #2;
    exp_zero("reset_outputs");
    cyc();
    cyc();
    clr = 1'b1;
    cyc();
    exp_zero("idle_after_reset");

    // and R1,R2,R3 with a single-cycle run pulse
    ir  = 32'h28918000;
    run = 1'b1;
    cyc(); run = 1'b0; exp_t0("and_t0");
    cyc(); exp_t1("and_t1");
    cyc(); exp_t2("and_t2");
    cyc(); exp_t3("and_t3", 2);
    cyc(); exp_t4("and_t4", 3, 4'd3);
    cyc(); exp_t5("and_t5", 1);
    cyc(); exp_zero("and_idle");
    cyc(); exp_zero("and_idle_hold");

    // sub R5,R5,R7 with three memory wait cycles in T1
    ir        = mk_ir(5'b00100, 4'd5, 4'd5, 4'd7);
    mem_ready = 1'b0;
    run       = 1'b1;
    cyc(); run = 1'b0; exp_t0("wait_t0"); c0 = cycle;
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp_t1($sformatf("wait_t1_%0d", i));
      if (i == 3) mem_ready = 1'b1;
    end
    cyc(); exp_t2("wait_t2");
    cyc(); exp_t3("wait_t3", 5);
    cyc(); exp_t4("wait_t4", 7, 4'd2);
    cyc(); exp_t5("wait_t5", 5);
    check_int("wait_latency", cycle - c0 + 1, 9);
    cyc(); exp_zero("wait_idle");

    // illegal opcode traps to FAULT and stays there until clr
    ir  = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
    run = 1'b1;
    cyc(); run = 1'b0; exp_t0("ill_t0");
    cyc(); exp_t1("ill_t1");
    cyc(); exp_t2("ill_t2");
    cyc(); exp_zero("ill_t3");
    for (int i = 0; i < 20; i++) begin
      cyc();
      exp_fault($sformatf("ill_fault_%0d", i));
      if (i == 5) run = 1'b1;
    end
    run = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    exp_zero("ill_clr_async");
    cyc();
    clr = 1'b1;
    cyc(); exp_zero("ill_idle_after_clr");

    // back-to-back add then sub (Ra=Rc) with run held high
    ir  = mk_ir(5'b00011, 4'd4, 4'd6, 4'd8);
    run = 1'b1;
    cyc(); exp_t0("b2b_add_t0");
    cyc(); exp_t1("b2b_add_t1");
    cyc(); exp_t2("b2b_add_t2");
    cyc(); exp_t3("b2b_add_t3", 6);
    cyc(); exp_t4("b2b_add_t4", 8, 4'd1);
    cyc(); exp_t5("b2b_add_t5", 4); d1 = cycle;
    ir = mk_ir(5'b00100, 4'd9, 4'd10, 4'd9);
    cyc(); exp_t0("b2b_sub_t0");
    cyc(); exp_t1("b2b_sub_t1");
    cyc(); exp_t2("b2b_sub_t2");
    cyc(); exp_t3("b2b_sub_t3", 10);
    cyc(); exp_t4("b2b_sub_t4", 9, 4'd2);
    cyc(); exp_t5("b2b_sub_t5", 9); d2 = cycle;
    run = 1'b0;
    check_int("b2b_done_gap", d2 - d1, 6);
    cyc(); exp_zero("b2b_idle");

    // asynchronous reset between edges while in T4
    ir  = mk_ir(5'b00110, 4'd12, 4'd13, 4'd14);
    run = 1'b1;
    cyc(); run = 1'b0; exp_t0("rst_t0");
    cyc(); cyc(); cyc();
    exp_t3("rst_t3", 13);
    cyc(); exp_t4("rst_t4", 14, 4'd4);
    #2;
    clr = 1'b0;
    #1;
    exp_zero("rst_async_t4");
    #10;
    exp_zero("rst_held");
    clr = 1'b1;
    cyc(); exp_zero("rst_idle_after");

    // reset during a T1 wait also aborts
    mem_ready = 1'b0;
    run       = 1'b1;
    cyc(); run = 1'b0; exp_t0("rstw_t0");
    cyc(); exp_t1("rstw_t1");
    cyc(); exp_t1("rstw_t1_wait");
    #2;
    clr = 1'b0;
    #1;
    exp_zero("rstw_async");
    mem_ready = 1'b1;
    #10;
    clr = 1'b1;
    cyc(); exp_zero("rstw_idle_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: OPW, default 5, opcode field width taken from ir[31:27].
REQ-002 Port: clk  in  1  rising-edge system clock.
REQ-003 Port: clr  in  1  reset; asynchronous, active-low.
REQ-004 Port: run  in  1  level; start or continue fetching instructions.
REQ-005 Port: ir  in  32  instruction register contents from the datapath.
REQ-006 Port: mem_ready  in  1  memory read data valid on MDataIn.
REQ-007 Port: enable  out  32  register-load strobes; R0-R15=[15:0], Zin=[18], Yin=[19], PCin=[20], MDRin=[21], IRin=[23], MARin=[25], IncPC=[27].
REQ-008 Port: busSelect  out  32  one-hot bus source; R0-R15=[15:0], Zhigh=[18], Zlow=[19], PC=[20], MDR=[21].
REQ-009 Port: MD_Read  out  1  MDR takes MDataIn instead of the bus.
REQ-010 Port: Control_Signals  out  4  ALU operation code.
REQ-011 Port: instr_done  out  1  one-cycle pulse on completion of an instruction.
REQ-012 Port: illegal  out  1  sticky; unsupported opcode decoded.

Function
REQ-013 Register-register instruction fields: opcode=ir[31:27], Ra (destination)=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-014 Supported opcodes and ALU codes: 00011 add->1, 00100 sub->2, 00101 and->3, 00110 or->4; every other opcode is illegal.
REQ-015 States: IDLE, T0, T1, T2, T3, T4, T5, FAULT; the state advances only on a clk rising edge.
REQ-016 Outputs are Moore, decoded from the state register and ir only; every output bit not listed for a state is 0.
REQ-017 IDLE: all outputs 0; go to T0 when run=1.
REQ-018 T0: busSelect[20], enable[25], enable[27], enable[18]; next state T1.
REQ-019 T1: busSelect[19], enable[20], enable[21], MD_Read; hold in T1 while mem_ready=0; go to T2 when mem_ready=1.
REQ-020 Repeated PCin during T1 wait cycles is permitted; Z is not reloaded, so PC remains PC+1.
REQ-021 T2: busSelect[21], enable[23]; next state T3.
REQ-022 T3: if the opcode is illegal, all outputs are 0, illegal is set and the next state is FAULT; otherwise busSelect[Rb] and enable[19] are asserted and the next state is T4.
REQ-023 T4: busSelect[Rc], enable[18], Control_Signals=ALU code; next state T5.
REQ-024 T5: busSelect[19], enable[Ra], instr_done=1; next state T0 if run=1, otherwise IDLE.
REQ-025 Deasserting run mid-instruction does not abort the instruction; the sequencer stops only after T5.
REQ-026 busSelect has at most one bit set in every cycle (one-hot or zero).
REQ-027 When Ra=Rb or Ra=Rc, behaviour is unchanged: the source is read in T3/T4 and the write occurs in T5.
REQ-028 FAULT: all outputs 0 except illegal=1; FAULT is left only by reset.
REQ-029 Single-instruction latency: 6 cycles (T0 to T5) with mem_ready=1 in the first T1 cycle, plus 1 cycle per T1 wait.

Reset
REQ-030 clr=0 forces IDLE immediately, regardless of clk.
REQ-031 While clr=0: enable=0, busSelect=0, MD_Read=0, Control_Signals=0, instr_done=0, illegal=0.
REQ-032 Reset in any state, including T1 wait and FAULT, aborts the instruction; the first state after release is IDLE.

Structure
REQ-033 Shared package ctrl_pkg contains: state enumeration; enable/busSelect bit-index constants; opcode constants; ALU code constants.
REQ-034 Sub-module alu_op_decode: combinational; maps opcode to {legal, ALU code}; instantiated once.
REQ-035 Single always block for the state register (async clr); separate combinational output decode; no latches.

Verification
REQ-036 and: ir=32'h28918000, mem_ready=1, run pulsed for 1 cycle -> T3 busSelect[2]/enable[19]; T4 busSelect[3]/enable[18]/Control_Signals=3; T5 busSelect[19]/enable[1]/instr_done; then IDLE.
REQ-037 Memory wait: mem_ready held 0 for 3 cycles in T1 -> MD_Read/enable[21] asserted for 4 cycles; T2 follows the cycle after mem_ready=1; total 9 cycles.
REQ-038 Illegal: ir opcode 11111 -> illegal=1 after T3, FAULT held for 20 cycles with busSelect=0 and enable=0; clr pulse -> IDLE, illegal=0.
REQ-039 Back-to-back: run held at 1 over an add then a sub -> T5 goes directly to T0; Control_Signals=1 then 2; two instr_done pulses 6 cycles apart.
REQ-040 Async reset: clr driven to 0 mid-T4, between clk edges -> all outputs 0 before the next edge; IDLE after release.
REQ-041 Assertion in every test: popcount(busSelect)<=1 and illegal is never cleared except by clr.
